// File: rtl/preproc_sequencer_if.sv
// Sample-stream and integrator-output handshake bundle for preproc_sequencer.
// Optional build macro: SEQ_SAMPLE_IDX_EN adds the m_idx sample index.
interface preproc_sequencer_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_valid;
  logic [12:0] m_data;
`ifdef SEQ_SAMPLE_IDX_EN
  logic [15:0] m_idx;

  modport master (output s_valid, s_data, input s_ready, m_valid, m_data, m_idx);
  modport slave  (input s_valid, s_data, output s_ready, m_valid, m_data, m_idx);
`else
  modport master (output s_valid, s_data, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, output s_ready, m_valid, m_data);
`endif
endinterface

// File: rtl/preproc_sequencer.sv
// Sequencer for the ECG preprocessing datapath: paces samples at a
// programmable rate, handles warm-up and flush, tags integrator outputs.
// Optional build macro: SEQ_SAMPLE_IDX_EN adds the m_idx output counter.
//
// state  | meaning
// IDLE   | stopped, tick generator held at 0
// WARMUP | feeding samples, integrator window not yet full
// RUN    | feeding samples, every tick yields an output
// FLUSH  | feeding zeros to drain the pipeline, every tick yields an output
module preproc_sequencer #(
  parameter int DIV_W     = 16,
  parameter int WARMUP    = 22,
  parameter int FLUSH_LEN = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_W-1:0]     cfg_div,
  preproc_sequencer_if.slave   sif,
  output logic                 pp_ce,
  output logic                 pp_clr,
  output logic [7:0]           pp_xin,
  input  logic [12:0]          pp_yout,
  output logic                 busy,
  output logic [1:0]           state_o,
  output logic                 underrun
);

  localparam int SEQ_MAX = (WARMUP > FLUSH_LEN) ? WARMUP : FLUSH_LEN;
  localparam int CNT_W   = $clog2(SEQ_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] per_cnt, div_q, div_eff;
  logic [CNT_W-1:0] seq_cnt;
  logic             tick, start, feed, out_pulse, warm_last, flush_last;
  logic             underrun_q, m_valid_q;
  logic [12:0]      m_data_q;

  // A zero divider behaves as one so the tick still fires every cycle.
  assign div_eff    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign tick       = (state != S_IDLE) && (per_cnt == div_q - DIV_W'(1));
  assign warm_last  = (seq_cnt == CNT_W'(WARMUP - 1));
  assign flush_last = (seq_cnt == CNT_W'(FLUSH_LEN - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; enable is ignored in FLUSH until the drain completes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (enable) state_nxt = S_WARMUP;
      S_WARMUP: begin
        if (!enable)                state_nxt = S_IDLE;
        else if (tick && warm_last) state_nxt = S_RUN;
      end
      S_RUN:    if (!enable) state_nxt = S_FLUSH;
      S_FLUSH:  if (tick && flush_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: start pulse, sample feed, and which ticks produce output.
  always_comb begin
    start     = 1'b0;
    feed      = 1'b0;
    out_pulse = 1'b0;
    unique case (state)
      S_IDLE:   start = enable;
      S_WARMUP: begin
        feed      = tick;
        out_pulse = tick && enable && warm_last;
      end
      S_RUN: begin
        feed      = tick;
        out_pulse = tick;
      end
      S_FLUSH:  out_pulse = tick;
      default:  ;
    endcase
  end

  assign pp_ce       = tick;
  assign pp_clr      = start;
  assign sif.s_ready = feed & sif.s_valid;
  assign pp_xin      = sif.s_ready ? sif.s_data : 8'd0;
  assign busy        = (state != S_IDLE);
  assign state_o     = state;
  assign underrun    = underrun_q;
  assign sif.m_valid = m_valid_q;
  assign sif.m_data  = m_data_q;

  // Period counter and warm-up/flush tick counter; divider resampled on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      div_q   <= DIV_W'(1);
      seq_cnt <= '0;
    end else if (start) begin
      per_cnt <= '0;
      div_q   <= div_eff;
      seq_cnt <= '0;
    end else if (state == S_IDLE) begin
      per_cnt <= '0;
    end else begin
      if (tick) begin
        per_cnt <= '0;
        div_q   <= div_eff;
      end else begin
        per_cnt <= per_cnt + DIV_W'(1);
      end
      if (state == S_RUN) seq_cnt <= '0;
      else if (tick)      seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end

  // Sticky underrun flag and registered integrator output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      if (start)                     underrun_q <= 1'b0;
      else if (feed && !sif.s_valid) underrun_q <= 1'b1;
      m_valid_q <= out_pulse;
      if (out_pulse) m_data_q <= pp_yout;
    end
  end

`ifdef SEQ_SAMPLE_IDX_EN
  logic [15:0] idx_nxt, m_idx_q;

  assign sif.m_idx = m_idx_q;

  // Output sample index, restarted with each run and wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_nxt <= '0;
      m_idx_q <= '0;
    end else if (start) begin
      idx_nxt <= '0;
      m_idx_q <= '0;
    end else if (out_pulse) begin
      m_idx_q <= idx_nxt;
      idx_nxt <= idx_nxt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_preproc_sequencer.sv
module tb_preproc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cfg_div;
  logic        pp_ce, pp_clr, busy, underrun;
  logic [7:0]  pp_xin;
  logic [12:0] pp_yout;
  logic [1:0]  state_o;
  int          tests_run = 0;
  int          tests_failed = 0;

  preproc_sequencer_if sif ();

  preproc_sequencer #(.DIV_W(16), .WARMUP(22), .FLUSH_LEN(22)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_div(cfg_div), .sif(sif),
    .pp_ce(pp_ce), .pp_clr(pp_clr), .pp_xin(pp_xin), .pp_yout(pp_yout),
    .busy(busy), .state_o(state_o), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: output steps by 7 on every clock enable.
  always @(posedge clk or posedge rst) begin
    if (rst)         pp_yout <= 13'd0;
    else if (pp_clr) pp_yout <= 13'd0;
    else if (pp_ce)  pp_yout <= pp_yout + 13'd7;
  end

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; cfg_div = 16'd4;
    sif.s_valid = 1'b0; sif.s_data = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if ({state_o, busy, pp_ce, pp_clr, pp_xin, sif.s_ready, sif.m_valid, sif.m_data, underrun} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got st=%0d busy=%0d ce=%0d clr=%0d xin=%0d rdy=%0d mv=%0d md=%0d ur=%0d expected all 0",
               state_o, busy, pp_ce, pp_clr, pp_xin, sif.s_ready, sif.m_valid, sif.m_data, underrun);
    end
  endtask

  task automatic test_warmup_run();
    logic [12:0] y_ce;
    logic exp_ce, exp_mv;
    logic [1:0] exp_st;
    y_ce = 13'd0;
    do_reset();
    cfg_div = 16'd4; sif.s_valid = 1'b1; sif.s_data = 8'sd64;
    @(negedge clk); enable = 1'b1; #1;
    tests_run++;
    if (pp_clr !== 1'b1 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL start_clr: got clr=%0d st=%0d expected clr=1 st=0", pp_clr, state_o);
    end
    for (int k = 1; k < 100; k++) begin
      @(negedge clk); #1;
      exp_ce = (k % 4 == 0);
      exp_mv = (k >= 89) && ((k - 89) % 4 == 0);
      exp_st = (k <= 88) ? 2'd1 : 2'd2;
      tests_run++;
      if (pp_ce !== exp_ce || sif.s_ready !== exp_ce || pp_clr !== 1'b0) begin
        tests_failed++;
        $display("FAIL warm_tick k=%0d: got ce=%0d rdy=%0d clr=%0d expected ce=%0d rdy=%0d clr=0",
                 k, pp_ce, sif.s_ready, pp_clr, exp_ce, exp_ce);
      end
      tests_run++;
      if (pp_xin !== (exp_ce ? 8'd64 : 8'd0)) begin
        tests_failed++;
        $display("FAIL warm_xin k=%0d: got %0d expected %0d", k, pp_xin, exp_ce ? 64 : 0);
      end
      tests_run++;
      if (sif.m_valid !== exp_mv || state_o !== exp_st) begin
        tests_failed++;
        $display("FAIL warm_mv k=%0d: got mv=%0d st=%0d expected mv=%0d st=%0d",
                 k, sif.m_valid, state_o, exp_mv, exp_st);
      end
      if (exp_mv) begin
        tests_run++;
        if (sif.m_data !== y_ce) begin
          tests_failed++;
          $display("FAIL run_mdata k=%0d: got %0d expected %0d", k, sif.m_data, y_ce);
        end
      end
      if (exp_ce) y_ce = pp_yout;
    end
  endtask

  // Continues from test_warmup_run: cycle 100 is a RUN tick.
  task automatic test_flush();
    int ce_n, sr_n, mv_n, clr_n, xin_n;
    ce_n = 0; sr_n = 0; mv_n = 0; clr_n = 0; xin_n = 0;
    @(negedge clk); enable = 1'b0; #1;
    tests_run++;
    if (pp_ce !== 1'b1 || sif.s_ready !== 1'b1 || state_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL fall_tick: got ce=%0d rdy=%0d st=%0d expected 1 1 2", pp_ce, sif.s_ready, state_o);
    end
    for (int k = 101; k <= 190; k++) begin
      @(negedge clk);
      if (k == 150) enable = 1'b1;
      #1;
      if (k <= 189) begin
        if (pp_ce) ce_n++;
        if (sif.s_ready) sr_n++;
        if (pp_xin != 8'd0) xin_n++;
      end
      if (k >= 102 && k <= 189 && sif.m_valid) mv_n++;
      if (k <= 188 && pp_clr) clr_n++;
      if (k == 189) begin
        tests_run++;
        if (state_o !== 2'd0 || pp_clr !== 1'b1 || sif.m_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL flush_end: got st=%0d clr=%0d mv=%0d expected st=0 clr=1 mv=1", state_o, pp_clr, sif.m_valid);
        end
      end
      if (k == 190) begin
        tests_run++;
        if (state_o !== 2'd1) begin
          tests_failed++;
          $display("FAIL restart_state: got %0d expected 1", state_o);
        end
      end
    end
    tests_run++;
    if (ce_n != 22 || mv_n != 22) begin
      tests_failed++;
      $display("FAIL flush_counts: got ce=%0d mv=%0d expected 22 22", ce_n, mv_n);
    end
    tests_run++;
    if (sr_n != 0 || xin_n != 0 || clr_n != 0) begin
      tests_failed++;
      $display("FAIL flush_quiet: got rdy=%0d xin=%0d clr=%0d expected 0 0 0", sr_n, xin_n, clr_n);
    end
  endtask

  task automatic test_div0();
    do_reset();
    cfg_div = 16'd0; sif.s_valid = 1'b1; sif.s_data = 8'd5;
    @(negedge clk); enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if (pp_ce !== 1'b1 || sif.m_valid !== (k >= 23)) begin
        tests_failed++;
        $display("FAIL div0 k=%0d: got ce=%0d mv=%0d expected ce=1 mv=%0d", k, pp_ce, sif.m_valid, k >= 23);
      end
    end
  endtask

  task automatic test_div_change();
    logic exp_ce;
    do_reset();
    cfg_div = 16'd4; sif.s_valid = 1'b1; sif.s_data = 8'd1;
    @(negedge clk); enable = 1'b1;
    for (int k = 1; k <= 115; k++) begin
      @(negedge clk);
      if (k == 94) cfg_div = 16'd8;
      #1;
      exp_ce = (k <= 96) ? (k % 4 == 0) : (k == 104 || k == 112);
      tests_run++;
      if (pp_ce !== exp_ce) begin
        tests_failed++;
        $display("FAIL div_change k=%0d: got ce=%0d expected %0d", k, pp_ce, exp_ce);
      end
    end
    cfg_div = 16'd4;
  endtask

  task automatic test_underrun();
    bit reached;
    do_reset();
    cfg_div = 16'd4; sif.s_valid = 1'b1; sif.s_data = 8'd33;
    @(negedge clk); enable = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      sif.s_valid = (k != 100);
      #1;
      if (k == 100) begin
        tests_run++;
        if (pp_ce !== 1'b1 || sif.s_ready !== 1'b0 || pp_xin !== 8'd0) begin
          tests_failed++;
          $display("FAIL underrun_tick: got ce=%0d rdy=%0d xin=%0d expected 1 0 0", pp_ce, sif.s_ready, pp_xin);
        end
      end
      tests_run++;
      if (underrun !== (k > 100)) begin
        tests_failed++;
        $display("FAIL underrun_flag k=%0d: got %0d expected %0d", k, underrun, k > 100);
      end
    end
    enable = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      @(negedge clk); #1;
      if (state_o == 2'd0) reached = 1'b1;
    end
    tests_run++;
    if (!reached || underrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_idle: got idle=%0d ur=%0d expected idle=1 ur=1", reached, underrun);
    end
    @(negedge clk); enable = 1'b1; #1;
    tests_run++;
    if (pp_clr !== 1'b1) begin
      tests_failed++;
      $display("FAIL underrun_restart_clr: got %0d expected 1", pp_clr);
    end
    @(negedge clk); #1;
    tests_run++;
    if (underrun !== 1'b0 || state_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL underrun_clear: got ur=%0d st=%0d expected ur=0 st=1", underrun, state_o);
    end
  endtask

  task automatic test_warmup_abort();
    do_reset();
    cfg_div = 16'd4; sif.s_valid = 1'b1; sif.s_data = 8'd9;
    @(negedge clk); enable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      enable = (k < 50);
      #1;
      tests_run++;
      if (sif.m_valid !== 1'b0 || state_o !== ((k <= 50) ? 2'd1 : 2'd0) || (k > 50 && pp_ce !== 1'b0)) begin
        tests_failed++;
        $display("FAIL warmup_abort k=%0d: got mv=%0d st=%0d ce=%0d expected mv=0 st=%0d",
                 k, sif.m_valid, state_o, pp_ce, (k <= 50) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cfg_div = 16'd4; sif.s_valid = 1'b1; sif.s_data = 8'd20;
    @(negedge clk); enable = 1'b1;
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk);
      sif.s_valid = (k != 96);
    end
    #1;
    tests_run++;
    if (state_o !== 2'd2 || underrun !== 1'b1 || sif.m_data === 13'd0) begin
      tests_failed++;
      $display("FAIL pre_reset_run: got st=%0d ur=%0d md=%0d expected st=2 ur=1 md!=0", state_o, underrun, sif.m_data);
    end
    @(negedge clk); rst = 1'b1; enable = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if ({state_o, busy, pp_ce, sif.m_valid, underrun, sif.m_data} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: got st=%0d busy=%0d ce=%0d mv=%0d ur=%0d md=%0d expected all 0",
               state_o, busy, pp_ce, sif.m_valid, underrun, sif.m_data);
    end
    rst = 1'b0;
  endtask

`ifdef SEQ_SAMPLE_IDX_EN
  task automatic test_idx();
    int p;
    p = 0;
    do_reset();
    cfg_div = 16'd1; sif.s_valid = 1'b1; sif.s_data = 8'd3;
    @(negedge clk); enable = 1'b1;
    for (int k = 1; k <= 65600 && p <= 65536; k++) begin
      @(negedge clk); #1;
      if (sif.m_valid) begin
        if (p == 0 || p == 9 || p == 65535 || p == 65536) begin
          tests_run++;
          if (sif.m_idx !== 16'(p)) begin
            tests_failed++;
            $display("FAIL m_idx pulse=%0d: got %0d expected %0d", p, sif.m_idx, 16'(p));
          end
        end
        p++;
      end
    end
    tests_run++;
    if (p <= 65536) begin
      tests_failed++;
      $display("FAIL idx_pulse_count: got %0d expected 65537", p);
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_warmup_run();
    test_flush();
    test_div0();
    test_div_change();
    test_underrun();
    test_warmup_abort();
    test_reset_mid_run();
`ifdef SEQ_SAMPLE_IDX_EN
    test_idx();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
